// File: rtl/lfsr_burst_arbiter_pkg.sv
// Shared types, constants and LFSR helpers for the burst arbiter slice.
// Implements the 8-bit Fibonacci polynomial x^8+x^6+x^5+x^4+1.
package lfsr_ctrl_pkg;

  // Engine width; the tap polynomial below only makes sense for 8 bits.
  localparam int LFSR_W = 8;

  // Feedback taps on state bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

  // Used in place of an all-zero seed (which would lock the LFSR) and as reset state.
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction

  // Replace a zero seed so the engine can never enter the all-zero lock-up state.
  function automatic logic [LFSR_W-1:0] effective_seed(input logic [LFSR_W-1:0] s,
                                                       input logic [LFSR_W-1:0] dflt);
    return (s == '0) ? dflt : s;
  endfunction

endpackage

// File: rtl/lfsr_burst_arbiter_if.sv
// Client-facing bundle of the burst arbiter: requests, seeds, lengths and the
// shared byte stream with its grant/done handshake.
interface lfsr_burst_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);

  logic              ena;
  logic [1:0]        req;
  logic [WIDTH-1:0]  seed0;
  logic [WIDTH-1:0]  seed1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [1:0]        gnt;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic              data_owner;
  logic [1:0]        done;
  logic              busy;

  // Client / environment side.
  modport master (
    output ena, req, seed0, seed1, len0, len1,
    input  gnt, data_out, data_valid, data_owner, done, busy
  );

  // Arbiter side.
  modport slave (
    input  ena, req, seed0, seed1, len0, len1,
    output gnt, data_out, data_valid, data_owner, done, busy
  );

endinterface

// File: rtl/lfsr_burst_arbiter_core.sv
// Bare LFSR register shared by all bursts. A load beats a step in the same
// cycle so a new seed is never stepped before it has been presented.
module lfsr_step_core
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;

  // Engine register: reset to the default seed, load has priority over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_SEED;
    end else if (load) begin
      state_reg <= seed;
    end else if (step) begin
      state_reg <= lfsr_next(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// Two-requester round-robin arbiter around a single LFSR engine. The winner's
// seed is loaded, the engine is stepped once per emitted byte for the requested
// length, and a one-cycle done pulse closes the burst. All outputs are registers.
module lfsr_burst_arbiter #(
  parameter int               WIDTH        = 8,
  parameter int               LEN_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_burst_arbiter_if.slave bus
);

  import lfsr_ctrl_pkg::*;

  arb_state_t       state_reg;
  logic [1:0]       gnt_reg;
  logic [1:0]       done_reg;
  logic             owner_reg;
  logic             last_owner_reg;
  logic             data_valid_reg;
  logic             busy_reg;
  logic [LEN_W-1:0] count_reg;

  logic             winner;
  logic [WIDTH-1:0] sel_seed;
  logic [WIDTH-1:0] eff_seed;
  logic [LEN_W-1:0] sel_len;
  logic [WIDTH-1:0] lfsr_q;
  logic             core_load;
  logic             core_step;

  // Round-robin pick: a lone requester wins outright; on a tie the requester
  // that was not served last goes first.
  always_comb begin
    winner = bus.req[1];
    if (bus.req[0] && bus.req[1]) begin
      winner = ~last_owner_reg;
    end
  end

  // Burst parameters come from the owner latched in IDLE, so a later change of
  // the other requester's inputs cannot leak into this burst.
  assign sel_seed = owner_reg ? bus.seed1 : bus.seed0;
  assign sel_len  = owner_reg ? bus.len1  : bus.len0;
  assign eff_seed = effective_seed(sel_seed, DEFAULT_SEED);

  // The engine only moves while enabled: seeded in LOAD, stepped in RUN. The
  // step on the final RUN edge advances past the last byte, which is harmless
  // because data_valid is low from then on and the next LOAD reseeds.
  assign core_load = (state_reg == LOAD) && bus.ena;
  assign core_step = (state_reg == RUN)  && bus.ena;

  lfsr_step_core #(
    .RESET_SEED (DEFAULT_SEED)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .step  (core_step),
    .seed  (eff_seed),
    .state (lfsr_q)
  );

  // Burst controller: arbitration, length counter and all registered outputs.
  // A RUN cycle with data_valid high presents one byte; the next enabled edge
  // consumes it (engine steps, count decrements). With ena low nothing moves
  // and data_valid drops, so a pause of k cycles stretches the burst by k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt_reg        <= 2'b00;
      done_reg       <= 2'b00;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      count_reg      <= '0;
    end else begin
      // done is a strict single-cycle pulse even if ena stalls the DONE state.
      done_reg <= 2'b00;
      if (!bus.ena) begin
        data_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (|bus.req) begin
              owner_reg <= winner;
              gnt_reg   <= winner ? 2'b10 : 2'b01;
              busy_reg  <= 1'b1;
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            count_reg <= sel_len;
            if (sel_len != '0) begin
              data_valid_reg <= 1'b1;
              state_reg      <= RUN;
            end else begin
              done_reg  <= gnt_reg;
              state_reg <= DONE;
            end
          end
          RUN: begin
            count_reg <= count_reg - 1'b1;
            if (count_reg == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              data_valid_reg <= 1'b0;
              done_reg       <= gnt_reg;
              state_reg      <= DONE;
            end else begin
              data_valid_reg <= 1'b1;
            end
          end
          DONE: begin
            gnt_reg        <= 2'b00;
            busy_reg       <= 1'b0;
            last_owner_reg <= owner_reg;
            state_reg      <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.done       = done_reg;
  assign bus.data_out   = lfsr_q;
  assign bus.data_valid = data_valid_reg;
  assign bus.data_owner = owner_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Directed bench for lfsr_burst_arbiter: a per-cycle vector table for the
// single-requester bursts, plus hand-written round-robin and reset sequences.
module tb_lfsr_burst_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lfsr_burst_arbiter_if #(.WIDTH(8), .LEN_W(8)) bus_if ();

  lfsr_burst_arbiter #(
    .WIDTH        (8),
    .LEN_W        (8),
    .DEFAULT_SEED (8'h01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    string      tag;
    logic       ena;
    logic [1:0] req;
    logic [7:0] seed0;
    logic [7:0] seed1;
    logic [7:0] len0;
    logic [7:0] len1;
    logic [1:0] x_gnt;
    logic       x_valid;
    logic [7:0] x_data;
    logic       x_owner;
    logic [1:0] x_done;
    logic       x_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         n_grant;
  int         last_done_cyc;
  int         valid_cnt;
  int         dn_seen;
  int         g_seen;
  logic [1:0] prev_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic e, input logic [1:0] r,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] l0, input logic [7:0] l1,
                              input logic [1:0] g, input logic v, input logic [7:0] d,
                              input logic o, input logic [1:0] dn, input logic b);
    vec_t x;
    x.tag = tag; x.ena = e; x.req = r; x.seed0 = s0; x.seed1 = s1; x.len0 = l0; x.len1 = l1;
    x.x_gnt = g; x.x_valid = v; x.x_data = d; x.x_owner = o; x.x_done = dn; x.x_busy = b;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"},   bus_if.gnt, 2'b00);
    chk({tag, ".valid"}, bus_if.data_valid, 1'b0);
    chk({tag, ".done"},  bus_if.done, 2'b00);
    chk({tag, ".busy"},  bus_if.busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.ena = 1'b1; bus_if.req = 2'b00;
    bus_if.seed0 = 8'h00; bus_if.seed1 = 8'h00; bus_if.len0 = 8'h00; bus_if.len1 = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst.owner", bus_if.data_owner, 1'b0);
    chk("rst.data",  bus_if.data_out, 8'h01);
    rst_n = 1'b1;
    cyc();
    chk_idle("rst.post");

    // A: seed 01, len 6 from requester 0.
    vecs.push_back(mk("A0", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("A1", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h01, 0, 2'b00, 1));
    vecs.push_back(mk("A2", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h02, 0, 2'b00, 1));
    vecs.push_back(mk("A3", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h04, 0, 2'b00, 1));
    vecs.push_back(mk("A4", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h08, 0, 2'b00, 1));
    vecs.push_back(mk("A5", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h11, 0, 2'b00, 1));
    vecs.push_back(mk("A6", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 1, 8'h23, 0, 2'b00, 1));
    vecs.push_back(mk("A7", 1, 2'b01, 8'h01, 8'h00, 8'd6, 8'd0, 2'b01, 0, 8'h00, 0, 2'b01, 1));
    vecs.push_back(mk("A8", 1, 2'b00, 8'h01, 8'h00, 8'd6, 8'd0, 2'b00, 0, 8'h00, 0, 2'b00, 0));
    // B: zero seed on requester 1 falls back to 01, len 3.
    vecs.push_back(mk("B0", 1, 2'b10, 8'h01, 8'h00, 8'd6, 8'd3, 2'b10, 0, 8'h00, 1, 2'b00, 1));
    vecs.push_back(mk("B1", 1, 2'b10, 8'h01, 8'h00, 8'd6, 8'd3, 2'b10, 1, 8'h01, 1, 2'b00, 1));
    vecs.push_back(mk("B2", 1, 2'b10, 8'h01, 8'h00, 8'd6, 8'd3, 2'b10, 1, 8'h02, 1, 2'b00, 1));
    vecs.push_back(mk("B3", 1, 2'b10, 8'h01, 8'h00, 8'd6, 8'd3, 2'b10, 1, 8'h04, 1, 2'b00, 1));
    vecs.push_back(mk("B4", 1, 2'b10, 8'h01, 8'h00, 8'd6, 8'd3, 2'b10, 0, 8'h00, 1, 2'b10, 1));
    vecs.push_back(mk("B5", 1, 2'b00, 8'h01, 8'h00, 8'd6, 8'd3, 2'b00, 0, 8'h00, 1, 2'b00, 0));
    // C: zero length -> straight to done, no bytes.
    vecs.push_back(mk("C0", 1, 2'b01, 8'h05, 8'h00, 8'd0, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("C1", 1, 2'b01, 8'h05, 8'h00, 8'd0, 8'd0, 2'b01, 0, 8'h00, 0, 2'b01, 1));
    vecs.push_back(mk("C2", 1, 2'b00, 8'h05, 8'h00, 8'd0, 8'd0, 2'b00, 0, 8'h00, 0, 2'b00, 0));
    // E: ena low in IDLE blocks the grant.
    vecs.push_back(mk("E0", 0, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b00, 0, 8'h00, 0, 2'b00, 0));
    // D: seed 08, len 4, ena low for 3 cycles after the first byte.
    vecs.push_back(mk("D0", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("D1", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 1, 8'h08, 0, 2'b00, 1));
    vecs.push_back(mk("D2", 0, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("D3", 0, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("D4", 0, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 0, 8'h00, 0, 2'b00, 1));
    vecs.push_back(mk("D5", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 1, 8'h11, 0, 2'b00, 1));
    vecs.push_back(mk("D6", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 1, 8'h23, 0, 2'b00, 1));
    vecs.push_back(mk("D7", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 1, 8'h47, 0, 2'b00, 1));
    vecs.push_back(mk("D8", 1, 2'b01, 8'h08, 8'h00, 8'd4, 8'd0, 2'b01, 0, 8'h00, 0, 2'b01, 1));
    vecs.push_back(mk("D9", 1, 2'b00, 8'h08, 8'h00, 8'd4, 8'd0, 2'b00, 0, 8'h00, 0, 2'b00, 0));

    foreach (vecs[i]) begin
      bus_if.ena   = vecs[i].ena;
      bus_if.req   = vecs[i].req;
      bus_if.seed0 = vecs[i].seed0;
      bus_if.seed1 = vecs[i].seed1;
      bus_if.len0  = vecs[i].len0;
      bus_if.len1  = vecs[i].len1;
      cyc();
      $display("vec %s: gnt=%b valid=%b data=%02h owner=%b done=%b busy=%b", vecs[i].tag,
               bus_if.gnt, bus_if.data_valid, bus_if.data_out, bus_if.data_owner, bus_if.done, bus_if.busy);
      chk({vecs[i].tag, ".gnt"},   bus_if.gnt, vecs[i].x_gnt);
      chk({vecs[i].tag, ".valid"}, bus_if.data_valid, vecs[i].x_valid);
      chk({vecs[i].tag, ".done"},  bus_if.done, vecs[i].x_done);
      chk({vecs[i].tag, ".busy"},  bus_if.busy, vecs[i].x_busy);
      if (vecs[i].x_valid) chk({vecs[i].tag, ".data"}, bus_if.data_out, vecs[i].x_data);
      if (vecs[i].x_busy)  chk({vecs[i].tag, ".owner"}, bus_if.data_owner, vecs[i].x_owner);
    end

    // Round robin from reset with both requesters held high, len 2 each.
    bus_if.req = 2'b00; bus_if.ena = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.seed0 = 8'h01; bus_if.seed1 = 8'h08; bus_if.len0 = 8'd2; bus_if.len1 = 8'd2;
    bus_if.req = 2'b11;
    n_grant = 0; last_done_cyc = -100; valid_cnt = 0; prev_gnt = 2'b00;
    for (int c = 0; c < 200 && n_grant < 4; c++) begin
      cyc();
      if (bus_if.data_valid) valid_cnt++;
      if (bus_if.done != 2'b00) begin
        last_done_cyc = c;
        chk("rr.bytes", valid_cnt, 2);
        valid_cnt = 0;
      end
      if (bus_if.gnt != 2'b00 && prev_gnt == 2'b00) begin
        $display("rr grant %0d at cycle %0d: gnt=%b owner=%b", n_grant, c, bus_if.gnt, bus_if.data_owner);
        if (n_grant > 0) chk("rr.gap", c - last_done_cyc, 2);
        chk("rr.gnt", bus_if.gnt, (n_grant % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr.owner", bus_if.data_owner, n_grant % 2);
        n_grant++;
      end
      prev_gnt = bus_if.gnt;
    end
    chk("rr.grants", n_grant, 4);
    bus_if.req = 2'b00;
    for (int c = 0; c < 50 && bus_if.busy; c++) cyc();
    chk("rr.drain", bus_if.busy, 1'b0);

    // Asynchronous reset in the middle of a burst.
    bus_if.seed0 = 8'h01; bus_if.len0 = 8'd6; bus_if.req = 2'b01;
    cyc();
    chk("mr.gnt", bus_if.gnt, 2'b01);
    cyc();
    chk("mr.run", bus_if.data_valid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus_if.req = 2'b00;
    #1;
    $display("mid-burst reset: gnt=%b busy=%b valid=%b data=%02h", bus_if.gnt, bus_if.busy, bus_if.data_valid, bus_if.data_out);
    chk_idle("mr.async");
    chk("mr.data", bus_if.data_out, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    dn_seen = 0; g_seen = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (bus_if.done != 2'b00) dn_seen++;
      if (bus_if.gnt != 2'b00) g_seen++;
    end
    chk("mr.nodone", dn_seen, 0);
    chk("mr.nognt", g_seen, 0);

    // Fresh burst after the reset: seed 11, len 2.
    bus_if.seed0 = 8'h11; bus_if.len0 = 8'd2; bus_if.req = 2'b01;
    cyc();
    chk("fr.gnt", bus_if.gnt, 2'b01);
    chk("fr.busy", bus_if.busy, 1'b1);
    cyc();
    chk("fr.v0", bus_if.data_valid, 1'b1);
    chk("fr.d0", bus_if.data_out, 8'h11);
    cyc();
    chk("fr.v1", bus_if.data_valid, 1'b1);
    chk("fr.d1", bus_if.data_out, 8'h23);
    cyc();
    chk("fr.done", bus_if.done, 2'b01);
    chk("fr.valid", bus_if.data_valid, 1'b0);
    bus_if.req = 2'b00;
    cyc();
    chk_idle("fr.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
